// File: rtl/eeprom_ram_bridge_if.sv
// Bus bundle for eeprom_ram_bridge: EEPROM-core strobes, single-port BRAM port,
// host load/dump port and dirty/autosave status.
interface eeprom_ram_bridge_if;
   logic [12:0] ee_addr;
   logic [7:0]  ee_d;
   logic        ee_wr;
   logic        ee_rd;
   logic [7:0]  ee_q;

   logic [12:0] mem_addr;
   logic [7:0]  mem_d;
   logic        mem_wr;
   logic [7:0]  mem_q;

   logic [12:0] hst_addr;
   logic [7:0]  hst_d;
   logic        hst_we;
   logic        hst_req;
   logic        hst_ack;
   logic [7:0]  hst_q;

   logic        dirty;
   logic        dirty_clr;
   logic        sav_req;

   // Bridge side.
   modport slave (
      input  ee_addr, ee_d, ee_wr, ee_rd,
      output ee_q,
      output mem_addr, mem_d, mem_wr,
      input  mem_q,
      input  hst_addr, hst_d, hst_we, hst_req,
      output hst_ack, hst_q,
      output dirty, sav_req,
      input  dirty_clr
   );

   // Environment side: EEPROM core, BRAM and host together.
   modport master (
      output ee_addr, ee_d, ee_wr, ee_rd,
      input  ee_q,
      input  mem_addr, mem_d, mem_wr,
      output mem_q,
      output hst_addr, hst_d, hst_we, hst_req,
      input  hst_ack, hst_q,
      input  dirty, sav_req,
      output dirty_clr
   );
endinterface

// File: rtl/eeprom_ram_bridge.sv
// Arbitrates one single-port BRAM between the EEPROM core (absolute priority) and a
// host port, tracks dirty state and pulses an autosave request after a quiet period.
// Optional write-compare (skip writes of unchanged bytes): define EEPROM_DIRTY_CMP_EN.
module eeprom_ram_bridge #(
   parameter logic [23:0] QUIET_CYC = 24'd5_000_000
) (
   input  logic                 clk,
   input  logic                 rst,
   eeprom_ram_bridge_if.slave   bus
);

   typedef enum logic [1:0] {
      H_IDLE,
      H_ACC,
      H_ACK
   } hst_state_e;

   // Terminal count; QUIET_CYC is expected to be at least 2.
   localparam logic [23:0] QUIET_LAST = QUIET_CYC - 24'd1;

   hst_state_e  hst_state_q;
   logic [7:0]  ee_q_q;
   logic [7:0]  hst_q_q;
   logic        hst_ack_q;
   logic        rd_pend_q;
   logic        dirty_q;
   logic [23:0] timer_q;
   logic [23:0] timer_d;
   logic        armed_q;
   logic        sav_req_q;

   logic        cmp_busy;
   logic        ee_strobe;
   logic        rd_fire;
   logic        hst_go;
   logic        wr_evt;

`ifdef EEPROM_DIRTY_CMP_EN
   logic        cmp_pend_q;
   logic [12:0] cmp_addr_q;
   logic [7:0]  cmp_d_q;
   logic        cmp_diff;

   // The cycle after an ee_wr belongs to the compare; strobes there are dropped.
   assign cmp_busy = cmp_pend_q;
   assign cmp_diff = cmp_pend_q && (bus.mem_q != cmp_d_q);
   assign wr_evt   = cmp_diff;
`else
   assign cmp_busy = 1'b0;
   assign wr_evt   = bus.ee_wr;
`endif

   assign ee_strobe = (bus.ee_wr || bus.ee_rd) && !cmp_busy;
   assign rd_fire   = bus.ee_rd && !cmp_busy;
   assign hst_go    = (hst_state_q == H_IDLE) && bus.hst_req && !ee_strobe && !cmp_busy;
   assign timer_d   = timer_q + 24'd1;

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      bus.mem_addr = bus.hst_addr;
      bus.mem_d    = bus.hst_d;
      bus.mem_wr   = 1'b0;
`ifdef EEPROM_DIRTY_CMP_EN
      if (cmp_pend_q) begin
         bus.mem_addr = cmp_addr_q;
         bus.mem_d    = cmp_d_q;
         bus.mem_wr   = cmp_diff;
      end else if (ee_strobe) begin
         bus.mem_addr = bus.ee_addr;
         bus.mem_d    = bus.ee_d;
         bus.mem_wr   = 1'b0;
      end
`else
      if (ee_strobe) begin
         bus.mem_addr = bus.ee_addr;
         bus.mem_d    = bus.ee_d;
         bus.mem_wr   = bus.ee_wr;
      end
`endif
      else if (hst_go) begin
         bus.mem_wr = bus.hst_we;
      end
      if (rst) begin
         bus.mem_wr = 1'b0;
      end
   end

   // Read data is passed straight through in T+1, then held in ee_q_q.
   assign bus.ee_q    = rd_pend_q ? bus.mem_q : ee_q_q;
   assign bus.hst_q   = hst_q_q;
   assign bus.hst_ack = hst_ack_q;
   assign bus.dirty   = dirty_q;
   assign bus.sav_req = sav_req_q;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         hst_state_q <= H_IDLE;
         ee_q_q      <= 8'h00;
         hst_q_q     <= 8'h00;
         hst_ack_q   <= 1'b0;
         rd_pend_q   <= 1'b0;
         dirty_q     <= 1'b0;
         timer_q     <= 24'd0;
         armed_q     <= 1'b0;
         sav_req_q   <= 1'b0;
`ifdef EEPROM_DIRTY_CMP_EN
         cmp_pend_q  <= 1'b0;
`endif
      end else begin
         rd_pend_q <= rd_fire;
         if (rd_pend_q) begin
            ee_q_q <= bus.mem_q;
         end

         // A host access issued in H_IDLE has its data on mem_q during H_ACC.
         case (hst_state_q)
            H_IDLE: begin
               if (hst_go) begin
                  hst_state_q <= H_ACC;
               end
            end
            H_ACC: begin
               hst_q_q     <= bus.mem_q;
               hst_ack_q   <= 1'b1;
               hst_state_q <= H_ACK;
            end
            H_ACK: begin
               hst_ack_q   <= 1'b0;
               hst_state_q <= H_IDLE;
            end
            default: begin
               hst_ack_q   <= 1'b0;
               hst_state_q <= H_IDLE;
            end
         endcase

`ifdef EEPROM_DIRTY_CMP_EN
         cmp_pend_q <= bus.ee_wr && !cmp_pend_q;
`endif

         if (wr_evt) begin
            dirty_q <= 1'b1;
         end else if (bus.dirty_clr) begin
            dirty_q <= 1'b0;
         end

         sav_req_q <= 1'b0;
         if (wr_evt) begin
            timer_q <= 24'd0;
            armed_q <= 1'b1;
         end else if (bus.dirty_clr) begin
            timer_q <= 24'd0;
            armed_q <= 1'b0;
         end else if (armed_q && dirty_q) begin
            timer_q <= timer_d;
            if (timer_d == QUIET_LAST) begin
               sav_req_q <= 1'b1;
               armed_q   <= 1'b0;
            end
         end
      end
   end

`ifdef EEPROM_DIRTY_CMP_EN
   // NOTE: pure datapath latches carry no reset; cmp_pend_q qualifies them.
   always_ff @(posedge clk) begin
      if (bus.ee_wr && !cmp_pend_q) begin
         cmp_addr_q <= bus.ee_addr;
         cmp_d_q    <= bus.ee_d;
      end
   end
`endif

endmodule

// File: tb/tb_eeprom_ram_bridge.sv
// Self-checking bench for eeprom_ram_bridge: BRAM model, shadow-memory reference model
// with dirty/autosave timing, vector table, directed corner cases and random traffic.
module tb_eeprom_ram_bridge;

   localparam logic [23:0] QUIET = 24'd100;
`ifdef EEPROM_DIRTY_CMP_EN
   localparam int CMP_EN = 1;
`else
   localparam int CMP_EN = 0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   eeprom_ram_bridge_if bus ();

   eeprom_ram_bridge #(.QUIET_CYC(QUIET)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Single-port BRAM with one-cycle read latency.
   logic [7:0] bram [0:8191];
   always @(posedge clk) begin
      if (bus.mem_wr) bram[bus.mem_addr] <= bus.mem_d;
      bus.mem_q <= bram[bus.mem_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: contents as the EEPROM/host have written them, plus dirty and autosave rules.
   logic [7:0] ref_mem [0:8191];
   bit mon_en  = 0;
   bit dirty_m = 0;
   bit armed_m = 0;
   bit pend_m  = 0;
   int last_wr = 0;

   initial begin
      bit wr_now;
      bit exp_sav;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            check("dirty", bus.dirty, dirty_m);
            exp_sav = armed_m && (cyc - last_wr == int'(QUIET));
            check("sav_req", bus.sav_req, exp_sav);
            if (exp_sav) armed_m = 0;
            if (rst) begin
               dirty_m = 0;
               armed_m = 0;
               pend_m  = 0;
            end else begin
               if (CMP_EN != 0) begin
                  // Effective write happens one cycle late and only if the byte changes.
                  wr_now = pend_m;
                  pend_m = 0;
                  if (bus.ee_wr && !wr_now) begin
                     pend_m = (ref_mem[bus.ee_addr] != bus.ee_d);
                     ref_mem[bus.ee_addr] = bus.ee_d;
                  end
               end else begin
                  wr_now = bus.ee_wr;
                  if (bus.ee_wr) ref_mem[bus.ee_addr] = bus.ee_d;
               end
               if (wr_now) begin
                  dirty_m = 1;
                  armed_m = 1;
                  last_wr = cyc;
               end else if (bus.dirty_clr) begin
                  dirty_m = 0;
                  armed_m = 0;
               end
            end
         end
      end
   end

   initial begin
      #(10 * 60000);
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   typedef struct {
      bit         wr;
      bit         rd;
      logic [12:0] addr;
      logic [7:0]  d;
      logic        exp_mem_wr;
      logic [7:0]  exp_q;
   } vec_t;

   vec_t vecs [8];
   logic [12:0] pool [8];

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic ee_write(input logic [12:0] a, input logic [7:0] d, output int wr_cyc);
      bus.ee_addr = a;
      bus.ee_d    = d;
      bus.ee_wr   = 1'b1;
      wr_cyc      = cyc;
      next();
      bus.ee_wr   = 1'b0;
      next();
   endtask

   task automatic ee_read_chk(input logic [12:0] a);
      logic [7:0] exp;
      exp         = ref_mem[a];
      bus.ee_addr = a;
      bus.ee_rd   = 1'b1;
      @(negedge clk);
      check("rd mem_addr", bus.mem_addr, a);
      check("rd mem_wr", bus.mem_wr, 1'b0);
      next();
      bus.ee_rd = 1'b0;
      @(negedge clk);
      check("rd ee_q T+1", bus.ee_q, exp);
      next();
      @(negedge clk);
      check("rd ee_q hold", bus.ee_q, exp);
      next();
   endtask

   // conc_off: -1 none, 0 EEPROM read with the request, 1 EEPROM read during H_ACC.
   task automatic host_op(input bit we, input logic [12:0] a, input logic [7:0] d,
                          input int conc_off, input logic [12:0] conc_addr);
      logic [7:0] exp_h;
      logic [7:0] exp_c;
      bit got;
      int lat;
      exp_h        = ref_mem[a];
      exp_c        = ref_mem[conc_addr];
      got          = 0;
      lat          = -1;
      bus.hst_addr = a;
      bus.hst_d    = d;
      bus.hst_we   = we;
      bus.hst_req  = 1'b1;
      bus.ee_addr  = conc_addr;
      for (int k = 0; k < 20 && !got; k++) begin
         bus.ee_rd = (k == conc_off);
         @(negedge clk);
         if (conc_off >= 0 && k == conc_off + 1) check("conc ee_q", bus.ee_q, exp_c);
         if (bus.hst_ack) begin
            got = 1;
            lat = k;
            if (!we) check("hst_q", bus.hst_q, exp_h);
         end
         next();
      end
      bus.ee_rd   = 1'b0;
      bus.hst_req = 1'b0;
      check("hst_ack seen", got, 1'b1);
      check("hst_ack latency", lat, (conc_off == 0) ? 3 : 2);
      @(negedge clk);
      check("hst_ack one cycle", bus.hst_ack, 1'b0);
      next();
      if (we) ref_mem[a] = d;
   endtask

   task automatic count_sav(input int n, output int cnt, output int first);
      cnt   = 0;
      first = -1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (bus.sav_req) begin
            if (cnt == 0) first = cyc;
            cnt++;
         end
         next();
      end
   endtask

   task automatic pulse_clr();
      bus.dirty_clr = 1'b1;
      next();
      bus.dirty_clr = 1'b0;
      next();
   endtask

   initial begin
      int wc, cnt, first, op, idx;
      logic [12:0] a;
      logic [7:0] d;

      for (int i = 0; i < 8192; i++) begin
         bram[i]    = 8'h00;
         ref_mem[i] = 8'h00;
      end
      bus.ee_addr = 13'h0055; bus.ee_d = 8'hEE; bus.ee_wr = 1'b1; bus.ee_rd = 1'b0;
      bus.hst_addr = '0; bus.hst_d = '0; bus.hst_we = 1'b0; bus.hst_req = 1'b0;
      bus.dirty_clr = 1'b0;
      rst = 1'b1;

      vecs[0] = '{1'b1, 1'b0, 13'h0010, 8'hA5, 1'b1, 8'h00};
      vecs[1] = '{1'b1, 1'b0, 13'h1FFF, 8'h3C, 1'b1, 8'h00};
      vecs[2] = '{1'b1, 1'b0, 13'h0000, 8'h81, 1'b1, 8'h00};
      vecs[3] = '{1'b0, 1'b1, 13'h0010, 8'h00, 1'b0, 8'hA5};
      vecs[4] = '{1'b0, 1'b1, 13'h1FFF, 8'h00, 1'b0, 8'h3C};
      vecs[5] = '{1'b0, 1'b1, 13'h0000, 8'h00, 1'b0, 8'h81};
      vecs[6] = '{1'b1, 1'b0, 13'h0010, 8'h5A, 1'b1, 8'h00};
      vecs[7] = '{1'b0, 1'b1, 13'h0010, 8'h00, 1'b0, 8'h5A};
      pool = '{13'h0000, 13'h0001, 13'h0010, 13'h0ABC, 13'h1000, 13'h1555, 13'h1FFE, 13'h1FFF};

      // Reset, with an EEPROM write strobe held during it.
      next();
      next();
      mon_en = 1;
      @(negedge clk);
      check("rst mem_wr", bus.mem_wr, 1'b0);
      check("rst ee_q", bus.ee_q, 8'h00);
      check("rst hst_q", bus.hst_q, 8'h00);
      check("rst hst_ack", bus.hst_ack, 1'b0);
      next();
      bus.ee_wr = 1'b0;
      rst = 1'b0;
      next();
      ee_read_chk(13'h0055);

      // Vector table: mux behaviour and read latency.
      foreach (vecs[i]) begin
         bus.ee_addr = vecs[i].addr;
         bus.ee_d    = vecs[i].d;
         bus.ee_wr   = vecs[i].wr;
         bus.ee_rd   = vecs[i].rd;
         @(negedge clk);
         check($sformatf("vec%0d mem_addr", i), bus.mem_addr, vecs[i].addr);
         check($sformatf("vec%0d mem_wr", i), bus.mem_wr, (CMP_EN != 0) ? 1'b0 : vecs[i].exp_mem_wr);
         if (vecs[i].wr) check($sformatf("vec%0d mem_d", i), bus.mem_d, vecs[i].d);
         next();
         bus.ee_wr = 1'b0;
         bus.ee_rd = 1'b0;
         @(negedge clk);
         if (vecs[i].rd) check($sformatf("vec%0d ee_q T+1", i), bus.ee_q, vecs[i].exp_q);
         next();
         @(negedge clk);
         if (vecs[i].rd) check($sformatf("vec%0d ee_q hold", i), bus.ee_q, vecs[i].exp_q);
         next();
      end

      // Write, read 20 cycles later, then host read colliding with an EEPROM read.
      ee_write(13'h0010, 8'hA5, wc);
      repeat (18) next();
      ee_read_chk(13'h0010);
      check("dirty after write", bus.dirty, 1'b1);
      host_op(1'b0, 13'h0010, 8'h00, 0, 13'h0010);
      host_op(1'b0, 13'h1FFF, 8'h00, 1, 13'h0000);

      // Host writes leave dirty alone.
      pulse_clr();
      host_op(1'b1, 13'h0ABC, 8'h77, -1, 13'h0000);
      host_op(1'b1, 13'h1FFF, 8'hC3, 1, 13'h0010);
      host_op(1'b0, 13'h0ABC, 8'h00, 0, 13'h1FFF);
      check("dirty after host writes", bus.dirty, 1'b0);
      ee_read_chk(13'h1FFF);

      // Autosave after a quiet period, exactly once.
      ee_write(13'h0123, 8'h11, wc);
      count_sav(250, cnt, first);
      check("sav pulses", cnt, 1);
      check("sav offset", first - wc, int'(QUIET) + CMP_EN);
      pulse_clr();
      check("dirty cleared", bus.dirty, 1'b0);

      // Clear and write together: write wins, timer starts from zero.
      bus.ee_addr = 13'h0124; bus.ee_d = 8'h22; bus.ee_wr = 1'b1; bus.dirty_clr = 1'b1;
      wc = cyc;
      next();
      bus.ee_wr = 1'b0; bus.dirty_clr = 1'b0;
      next();
      @(negedge clk);
      check("clr+wr dirty", bus.dirty, 1'b1);
      count_sav(200, cnt, first);
      check("clr+wr sav pulses", cnt, 1);
      check("clr+wr sav offset", first - wc, int'(QUIET) + CMP_EN);

      // Clearing mid-count disarms the timer.
      ee_write(13'h0125, 8'h33, wc);
      repeat (30) next();
      pulse_clr();
      count_sav(200, cnt, first);
      check("disarmed sav pulses", cnt, 0);

      // Reset during H_ACC of a host write: no ack, request dropped.
      ee_write(13'h0200, 8'h99, wc);
      bus.hst_addr = 13'h0300; bus.hst_d = 8'h42; bus.hst_we = 1'b1; bus.hst_req = 1'b1;
      next();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i > 0) check("rst mid-access hst_ack", bus.hst_ack, 1'b0);
         next();
         bus.hst_req = 1'b0;
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post-rst hst_ack", bus.hst_ack, 1'b0);
         check("post-rst ee_q", bus.ee_q, 8'h00);
         next();
      end
      host_op(1'b1, 13'h0300, 8'h42, -1, 13'h0000);
      host_op(1'b0, 13'h0300, 8'h00, 0, 13'h0200);

`ifdef EEPROM_DIRTY_CMP_EN
      // Rewriting an unchanged byte is suppressed; a changed byte writes in T+1.
      ee_write(13'h0010, 8'hA5, wc);
      pulse_clr();
      bus.ee_addr = 13'h0010; bus.ee_d = 8'hA5; bus.ee_wr = 1'b1;
      @(negedge clk);
      check("cmp same T mem_wr", bus.mem_wr, 1'b0);
      next();
      bus.ee_wr = 1'b0;
      @(negedge clk);
      check("cmp same T+1 mem_wr", bus.mem_wr, 1'b0);
      next();
      @(negedge clk);
      check("cmp same dirty", bus.dirty, 1'b0);
      next();
      bus.ee_d = 8'h5A; bus.ee_wr = 1'b1;
      @(negedge clk);
      check("cmp diff T mem_wr", bus.mem_wr, 1'b0);
      next();
      bus.ee_wr = 1'b0;
      @(negedge clk);
      check("cmp diff T+1 mem_wr", bus.mem_wr, 1'b1);
      check("cmp diff T+1 mem_addr", bus.mem_addr, 13'h0010);
      check("cmp diff T+1 mem_d", bus.mem_d, 8'h5A);
      next();
      @(negedge clk);
      check("cmp diff dirty", bus.dirty, 1'b1);
      next();
`endif

      // Random traffic against the reference model.
      for (int it = 0; it < 200; it++) begin
         op  = $urandom_range(0, 6);
         idx = $urandom_range(0, 7);
         a   = pool[idx];
         d   = 8'($urandom);
         case (op)
            0, 1: ee_write(a, d, wc);
            2:    ee_read_chk(a);
            3:    host_op(1'b0, a, 8'h00, $urandom_range(0, 2) - 1, pool[(idx + 1) % 8]);
            4:    host_op(1'b1, a, d, $urandom_range(0, 2) - 1, pool[(idx + 3) % 8]);
            5:    pulse_clr();
            default: repeat ($urandom_range(1, 40)) next();
         endcase
      end
      foreach (pool[i]) ee_read_chk(pool[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/eeprom_ram_bridge.md
EEPROM_RAM_BRIDGE -- requirements
Module: eeprom_ram_bridge

Interface
REQ-001 Parameter QUIET_CYC, default 24'd5_000_000: number of idle cycles after the last EEPROM write before sav_req pulses.
REQ-002 clk  in  1  single bus clock; every register is clocked on its rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 ee_addr  in  13  EEPROM-side address, already masked by the EEPROM core.
REQ-005 ee_d  in  8  EEPROM-side write data.
REQ-006 ee_wr  in  1  one-cycle write strobe.
REQ-007 ee_rd  in  1  one-cycle read strobe.
REQ-008 ee_q  out  8  EEPROM-side read data.
REQ-009 mem_addr  out  13  address to the single-port BRAM, which has 1-cycle read latency.
REQ-010 mem_d  out  8  BRAM write data.
REQ-011 mem_wr  out  1  BRAM write enable.
REQ-012 mem_q  in  8  BRAM read data.
REQ-013 hst_addr  in  13  host (save load/dump) address.
REQ-014 hst_d  in  8  host write data.
REQ-015 hst_we  in  1  host request is a write when high.
REQ-016 hst_req  in  1  host request; level, held until hst_ack.
REQ-017 hst_ack  out  1  one-cycle completion pulse.
REQ-018 hst_q  out  8  host read data, valid while hst_ack is high.
REQ-019 dirty  out  1  high when EEPROM contents have changed since the last dirty_clr.
REQ-020 dirty_clr  in  1  one-cycle clear of dirty, issued by the host after a dump.
REQ-021 sav_req  out  1  one-cycle autosave request.

Function
REQ-022 The EEPROM side has absolute priority: in any cycle where ee_rd or ee_wr is high, the block SHALL drive mem_addr=ee_addr combinationally in that same cycle.
- ee_wr cycle: mem_d=ee_d and mem_wr=1.
- ee_rd cycle: mem_wr=0.
REQ-023 For ee_rd at cycle T, ee_q SHALL equal mem_q during cycle T+1 and SHALL hold that value from T+2 until the next ee_rd.
REQ-024 Host FSM states:
- H_IDLE -> H_ACC: when hst_req=1 and there is no EEPROM strobe and no compare in progress this cycle; mem is driven from hst_addr/hst_d/hst_we.
- H_ACC -> H_ACK: unconditional; hst_q is captured from mem_q.
- H_ACK -> H_IDLE: hst_ack=1 for exactly one cycle.
REQ-025 Host access when an EEPROM strobe arrives:
- Strobe in the same cycle as the H_IDLE request: the host access is deferred to the next free cycle.
- Strobe during H_ACC or H_ACK: the strobe preempts the mem port (REQ-022); the host access already issued is unaffected because its data was captured in H_ACC.
REQ-026 Host writes SHALL NOT set dirty or affect the quiet timer.
REQ-027 dirty SHALL set one cycle after an EEPROM write (see REQ-035 when compare is compiled in).
- dirty_clr clears dirty.
- Set and clear in the same cycle: set wins.
REQ-028 Quiet timer (24-bit):
- Reset to 0 on every EEPROM write.
- Increments while dirty=1 and the timer is armed.
- On reaching QUIET_CYC-1, sav_req pulses once and the timer disarms.
- It re-arms only on the next EEPROM write.
REQ-029 dirty_clr SHALL disarm and zero the timer unless a write sets dirty in the same cycle.
REQ-030 Addresses SHALL pass unmodified, with no wrap logic; the maximum 13'h1FFF is valid.

Reset
REQ-031 Reset values:
- Outputs: ee_q=8'h00, hst_q=8'h00, hst_ack=0, dirty=0, sav_req=0, mem_wr=0.
- State: host FSM=H_IDLE, timer=0 and disarmed.
REQ-032 A reset mid host access SHALL drop the request with no hst_ack; the host re-issues it.
REQ-033 A strobe coincident with rst SHALL be ignored: mem_wr=0.

Configuration
REQ-034 Macro EEPROM_DIRTY_CMP_EN: when undefined, every ee_wr writes directly in its own cycle and sets dirty.
REQ-035 When EEPROM_DIRTY_CMP_EN is defined, ee_wr at cycle T proceeds as follows:
- Cycle T: the old byte is read (mem_wr=0) and ee_addr/ee_d are latched.
- Cycle T+1: mem_q is compared with the latched data.
- If different: the byte is written in T+1, dirty sets, and the timer resets.
- If equal: no write, dirty is unchanged, and the timer is not reset.
- The host is blocked in both T and T+1.
- An ee_rd in T+1 (not legal from the EEPROM core) SHALL be ignored.

Verification
REQ-036 ee_wr addr 13'h0010 d 8'hA5, then ee_rd at the same address 20 cycles later -> ee_q=8'hA5 one cycle after ee_rd; dirty=1.
REQ-037 hst_req read at 13'h0010 asserted in the same cycle as ee_rd -> the EEPROM is served first; hst_ack arrives 3 cycles later with hst_q=8'hA5.
REQ-038 QUIET_CYC=100, one ee_wr -> exactly one sav_req pulse 100 cycles after the write; none thereafter; dirty_clr then drops dirty.
REQ-039 dirty_clr and ee_wr in the same cycle -> dirty=1 afterwards and the timer is armed from 0.
REQ-040 With EEPROM_DIRTY_CMP_EN defined, rewrite 8'hA5 to 13'h0010 after dirty_clr -> mem_wr stays 0 and dirty stays 0; writing 8'h5A -> mem_wr=1 in T+1 and dirty=1.
REQ-041 rst asserted during H_ACC of a host write -> no hst_ack; hst_ack=0 and dirty=0 after reset.
